// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin owner of the shared I2C transmitter for two FWFT byte streams.
// Optional watchdog abort enabled by `define I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter #(
   parameter int MAX_LEN     = 16,
   parameter int LEN_W       = 8,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int TO_W        = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_rd,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_rd,
   output logic       i2c_en,
   output logic [7:0] i2c_data,
   output logic       i2c_data_ready,
   input  logic       i2c_data_req,
   input  logic       i2c_done,
   output logic [1:0] grant,
   output logic       busy,
   output logic       err_len,
   output logic       err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_START,
      S_XFER,
      S_WAIT,
      S_FLUSH
   } state_t;

   localparam logic [7:0] MAX_B = 8'(MAX_LEN);

   if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
      $error("MAX_LEN must be 1..255");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_to_w
      $error("TO_W too narrow for TIMEOUT_CYC");
   end

   state_t           state;
   state_t           state_n;
   logic [1:0]       grant_n;
   logic             last;
   logic             last_n;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] rem_n;
   logic             pop;
   logic             own;
   logic             cur_valid;
   logic [7:0]       cur_data;
   logic             to_hit;
   logic             err_to;

   assign own       = grant[1];
   assign cur_valid = own ? req1_valid : req0_valid;
   assign cur_data  = own ? req1_data : req0_data;

   // pop is only ever raised with cur_valid high, so each strobe is backed by data
   assign req0_rd     = pop & grant[0];
   assign req1_rd     = pop & grant[1];
   assign busy        = (state != S_IDLE);
   assign err_timeout = err_to;

`ifdef I2C_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   // LEN always precedes START, so clearing there restarts the count at START
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == S_LEN) begin
         to_cnt <= '0;
      end else if (state != S_IDLE) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign to_hit = (state inside {S_START, S_XFER, S_WAIT, S_FLUSH}) &&
                   (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         grant <= 2'b00;
         last  <= 1'b1;
         rem   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         last  <= last_n;
         rem   <= rem_n;
      end
   end

   always_comb begin
      state_n        = state;
      grant_n        = grant;
      last_n         = last;
      rem_n          = rem;
      pop            = 1'b0;
      i2c_en         = 1'b0;
      i2c_data       = 8'h00;
      i2c_data_ready = 1'b0;
      err_len        = 1'b0;
      err_to         = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               // on a tie the requester that did not go last wins
               if (req1_valid && (!req0_valid || !last)) begin
                  grant_n = 2'b10;
               end else begin
                  grant_n = 2'b01;
               end
               state_n = S_LEN;
            end
         end

         S_LEN: begin
            if (cur_valid) begin
               pop = 1'b1;
               if (cur_data == 8'h00 || cur_data > MAX_B) begin
                  err_len = 1'b1;
                  grant_n = 2'b00;
                  last_n  = own;
                  state_n = S_IDLE;
               end else begin
                  rem_n   = LEN_W'(cur_data);
                  state_n = S_START;
               end
            end
         end

         S_START: begin
            i2c_en  = 1'b1;
            state_n = S_XFER;
         end

         S_XFER: begin
            i2c_data       = cur_data;
            i2c_data_ready = cur_valid && (rem != '0);
            if (i2c_data_ready && i2c_data_req) begin
               pop   = 1'b1;
               rem_n = rem - LEN_W'(1);
            end
            if (pop && rem_n == '0) begin
               if (i2c_done) begin
                  grant_n = 2'b00;
                  last_n  = own;
                  state_n = S_IDLE;
               end else begin
                  state_n = S_WAIT;
               end
            end else if (i2c_done) begin
               state_n = S_FLUSH;
            end
         end

         S_WAIT: begin
            if (i2c_done) begin
               grant_n = 2'b00;
               last_n  = own;
               state_n = S_IDLE;
            end
         end

         S_FLUSH: begin
            // drain the aborted payload so the next length byte lines up
            if (cur_valid && rem != '0) begin
               pop   = 1'b1;
               rem_n = rem - LEN_W'(1);
            end
            if (rem_n == '0) begin
               grant_n = 2'b00;
               last_n  = own;
               state_n = S_IDLE;
            end
         end

         default: begin
            grant_n = 2'b00;
            state_n = S_IDLE;
         end
      endcase

      if (to_hit) begin
         err_to  = 1'b1;
         grant_n = 2'b00;
         last_n  = own;
         state_n = S_IDLE;
      end
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter: FWFT requester models, a transmitter model,
// and a monitor that checks start pulses, sent bytes and error pulses in order.
module tb_i2c_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_rd;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_rd;
   logic       i2c_en;
   logic [7:0] i2c_data;
   logic       i2c_data_ready;
   logic       i2c_data_req = 1'b0;
   logic       i2c_done = 1'b0;
   logic [1:0] grant;
   logic       busy;
   logic       err_len;
   logic       err_timeout;

   i2c_cmd_arbiter #(
      .MAX_LEN    (16),
      .LEN_W      (8),
      .TIMEOUT_CYC(100),
      .TO_W       (21)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req0_valid    (req0_valid),
      .req0_data     (req0_data),
      .req0_rd       (req0_rd),
      .req1_valid    (req1_valid),
      .req1_data     (req1_data),
      .req1_rd       (req1_rd),
      .i2c_en        (i2c_en),
      .i2c_data      (i2c_data),
      .i2c_data_ready(i2c_data_ready),
      .i2c_data_req  (i2c_data_req),
      .i2c_done      (i2c_done),
      .grant         (grant),
      .busy          (busy),
      .err_len       (err_len),
      .err_timeout   (err_timeout)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] K_EN  = 2'd0;
   localparam logic [1:0] K_BYT = 2'd1;
   localparam logic [1:0] K_LEN = 2'd2;
   localparam logic [1:0] K_TO  = 2'd3;

   typedef struct packed {
      logic [1:0] k;
      logic [1:0] g;
      logic [7:0] d;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         done_q[$];

   int n_chk = 0;
   int n_pass = 0;
   bit p0 = 0;
   bit p1 = 0;
   bit x_act = 0;
   bit x_coinc = 0;
   bit x_dpend = 0;
   int x_dly = 3;
   int x_nreq = 0;
   int x_wait = 0;
   int x_tgt = 0;
   int nbytes = 0;
   int n_rd0 = 0;
   int n_rd1 = 0;
   int cyc = 0;
   int en_cyc = 0;
   int to_diff = -1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, act, req);
   endtask

   task automatic expect_ev(input string nm, input logic [1:0] k,
                            input logic [1:0] g, input logic [7:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL %s unexpected: got g=%b d=%h required no event",
                  nm, g, d);
      end else begin
         e = exp_q.pop_front();
         chk(nm, 32'({k, g, d}), 32'({e.k, e.g, e.d}));
      end
   endtask

   // requester FIFOs, transmitter model and monitor share one clocked loop:
   // drive on the falling edge, sample 1 ns before the rising edge
   always begin
      @(negedge clk);
      if (p0 && q0.size() != 0) void'(q0.pop_front());
      if (p1 && q1.size() != 0) void'(q1.pop_front());
      p0 = 0;
      p1 = 0;
      req0_valid = (q0.size() != 0);
      req0_data  = req0_valid ? q0[0] : 8'h00;
      req1_valid = (q1.size() != 0);
      req1_data  = req1_valid ? q1[0] : 8'h00;
      i2c_data_req = x_act && (x_wait >= x_dly);
      i2c_done = x_dpend ||
                 (x_coinc && i2c_data_req && (x_nreq + 1 == x_tgt));
      x_dpend = 0;
      #4;
      cyc++;
      if (rst) begin
         x_act = 0;
         x_dpend = 0;
      end else begin
         p0 = req0_rd;
         p1 = req1_rd;
         if (req0_rd) begin
            n_rd0++;
            chk("rd0_legal",
                32'(req0_valid && grant == 2'b01 && !req1_rd), 32'd1);
         end
         if (req1_rd) begin
            n_rd1++;
            chk("rd1_legal",
                32'(req1_valid && grant == 2'b10 && !req0_rd), 32'd1);
         end
         if (i2c_en) begin
            expect_ev("start", K_EN, grant, 8'h00);
            x_act = 1;
            x_nreq = 0;
            x_wait = 0;
            x_tgt = (done_q.size() != 0) ? done_q.pop_front() : 0;
            en_cyc = cyc;
         end
         if (i2c_data_ready && i2c_data_req) begin
            expect_ev("byte", K_BYT, grant, i2c_data);
            nbytes++;
            x_nreq++;
            x_wait = 0;
            if (x_nreq == x_tgt) begin
               x_act = 0;
               x_dpend = !x_coinc;
            end
         end else if (i2c_data_ready && x_act) begin
            x_wait++;
         end
         if (err_len) expect_ev("err_len", K_LEN, grant, 8'h00);
         if (err_timeout) begin
            expect_ev("err_timeout", K_TO, grant, 8'h00);
            x_act = 0;
            to_diff = cyc - en_cyc;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #4;
      end
   endtask

   task automatic ev(input logic [1:0] k, input logic [1:0] g,
                     input logic [7:0] d);
      ev_t e;
      e.k = k;
      e.g = g;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int i = 0;
      tick(3);
      while ((busy || q0.size() != 0 || q1.size() != 0 ||
              exp_q.size() != 0) && i < budget) begin
         tick(1);
         i++;
      end
      chk({nm, "_idle"}, 32'(i < budget), 32'd1);
      chk({nm, "_grant"}, 32'(grant), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int base;
      int rd_base;
      tick(3);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", 32'({i2c_en, i2c_data_ready, err_len, err_timeout,
                           req0_rd, req1_rd}), 32'd0);
      chk("rst_data", 32'(i2c_data), 32'd0);
      rst = 1'b0;

      // single req0 packet
      rd_base = n_rd0;
      done_q.push_back(2);
      ev(K_EN, 2'b01, 8'h00);
      ev(K_BYT, 2'b01, 8'hA4);
      ev(K_BYT, 2'b01, 8'h5C);
      q0.push_back(8'h02);
      q0.push_back(8'hA4);
      q0.push_back(8'h5C);
      wait_idle("t1", 300);
      chk("t1_rd0_count", 32'(n_rd0 - rd_base), 32'd3);

      // both requesters valid out of reset: strict alternation
      rst = 1'b1;
      tick(2);
      repeat (4) done_q.push_back(1);
      ev(K_EN, 2'b01, 8'h00);
      ev(K_BYT, 2'b01, 8'h11);
      ev(K_EN, 2'b10, 8'h00);
      ev(K_BYT, 2'b10, 8'h21);
      ev(K_EN, 2'b01, 8'h00);
      ev(K_BYT, 2'b01, 8'h12);
      ev(K_EN, 2'b10, 8'h00);
      ev(K_BYT, 2'b10, 8'h22);
      q0.push_back(8'h01);
      q0.push_back(8'h11);
      q0.push_back(8'h01);
      q0.push_back(8'h12);
      q1.push_back(8'h01);
      q1.push_back(8'h21);
      q1.push_back(8'h01);
      q1.push_back(8'h22);
      tick(2);
      rst = 1'b0;
      wait_idle("t2", 400);

      // zero length byte, then a good packet
      done_q.push_back(1);
      ev(K_LEN, 2'b10, 8'h00);
      ev(K_EN, 2'b10, 8'h00);
      ev(K_BYT, 2'b10, 8'h7F);
      q1.push_back(8'h00);
      q1.push_back(8'h01);
      q1.push_back(8'h7F);
      wait_idle("t3", 300);

      // early done: remaining two bytes flushed
      rd_base = n_rd0;
      base = nbytes;
      done_q.push_back(2);
      ev(K_EN, 2'b01, 8'h00);
      ev(K_BYT, 2'b01, 8'hA1);
      ev(K_BYT, 2'b01, 8'hA2);
      q0.push_back(8'h04);
      q0.push_back(8'hA1);
      q0.push_back(8'hA2);
      q0.push_back(8'hA3);
      q0.push_back(8'hA4);
      wait_idle("t4", 300);
      chk("t4_rd0_count", 32'(n_rd0 - rd_base), 32'd5);
      chk("t4_sent", 32'(nbytes - base), 32'd2);

      // underrun after first byte
      base = nbytes;
      done_q.push_back(3);
      ev(K_EN, 2'b01, 8'h00);
      ev(K_BYT, 2'b01, 8'hB1);
      ev(K_BYT, 2'b01, 8'hB2);
      ev(K_BYT, 2'b01, 8'hB3);
      q0.push_back(8'h03);
      q0.push_back(8'hB1);
      begin
         int i = 0;
         while (nbytes == base && i < 200) begin
            tick(1);
            i++;
         end
      end
      chk("t5_first", 32'(nbytes - base), 32'd1);
      for (int k = 0; k < 50; k++) begin
         tick(1);
         if (k == 10 || k == 49) begin
            chk("t5_ready_low", 32'(i2c_data_ready), 32'd0);
            chk("t5_grant_held", 32'(grant), 32'd1);
         end
      end
      q0.push_back(8'hB2);
      q0.push_back(8'hB3);
      wait_idle("t5", 300);

      // done coincident with the last data_req
      x_coinc = 1;
      done_q.push_back(1);
      ev(K_EN, 2'b10, 8'h00);
      ev(K_BYT, 2'b10, 8'hE5);
      q1.push_back(8'h01);
      q1.push_back(8'hE5);
      wait_idle("t7", 200);
      x_coinc = 0;

      // length one above the maximum
      ev(K_LEN, 2'b01, 8'h00);
      q0.push_back(8'h11);
      wait_idle("t8", 100);

      // length exactly at the maximum
      done_q.push_back(16);
      ev(K_EN, 2'b01, 8'h00);
      q0.push_back(8'h10);
      for (int i = 0; i < 16; i++) begin
         ev(K_BYT, 2'b01, 8'(8'h40 + i));
         q0.push_back(8'(8'h40 + i));
      end
      wait_idle("t9", 400);

      // transmitter never signals done
      done_q.push_back(0);
      ev(K_EN, 2'b01, 8'h00);
      ev(K_BYT, 2'b01, 8'hC3);
`ifdef I2C_ARB_TIMEOUT_EN
      ev(K_TO, 2'b01, 8'h00);
      q0.push_back(8'h01);
      q0.push_back(8'hC3);
      wait_idle("t6", 400);
      chk("t6_to_cycle", 32'(to_diff), 32'd99);
`else
      q0.push_back(8'h01);
      q0.push_back(8'hC3);
      tick(300);
      chk("t6_busy_held", 32'(busy), 32'd1);
      chk("t6_grant_held", 32'(grant), 32'd1);
      chk("t6_events", 32'(exp_q.size()), 32'd0);
      chk("t6_no_timeout", 32'(err_timeout), 32'd0);
      rst = 1'b1;
      tick(2);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      rst = 1'b0;
      tick(2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
